round_robin_arbiter: RTL

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold time and
// preemption of a long-running owner when other requesters are waiting.

module parallel_finder #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    onehot = vec & (~vec + N'(1));
    found  = |vec;
    index  = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) index = index | IW'(i);
    end
  end

endmodule

module round_robin_arbiter #(
  parameter int REQ_NUM  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         req,
  output logic [REQ_NUM-1:0]         grant,
  output logic [$clog2(REQ_NUM)-1:0] grant_index,
  output logic                       grant_valid,
  output logic                       preempt
);

  localparam int IW = $clog2(REQ_NUM);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_d;
  logic [IW-1:0]        ptr, ptr_d;
  logic [HW-1:0]        hold_cnt, hold_d;
  logic [REQ_NUM-1:0]   grant_d;
  logic [IW-1:0]        index_d;
  logic                 valid_d, preempt_d;

  logic [IW-1:0]        owner_next, search_base;
  logic [REQ_NUM-1:0]   search_vec, ge_mask, masked_vec;
  logic                 hi_found, lo_found;
  logic [REQ_NUM-1:0]   hi_onehot, lo_onehot, win_onehot;
  logic [IW-1:0]        hi_index, lo_index, win_index;
  logic                 owner_req;

  // While granting, the search starts after the owner and the owner is
  // excluded, so a switch always lands on a different requester.
  always_comb begin
    owner_next  = grant_index + IW'(1);
    search_base = (state == GRANT) ? owner_next : ptr;
    search_vec  = (state == GRANT) ? (req & ~grant) : req;
    ge_mask     = {REQ_NUM{1'b1}} << search_base;
    masked_vec  = search_vec & ge_mask;
  end

  parallel_finder #(.N(REQ_NUM), .IW(IW)) u_find_hi (
    .vec    (masked_vec),
    .found  (hi_found),
    .onehot (hi_onehot),
    .index  (hi_index)
  );

  parallel_finder #(.N(REQ_NUM), .IW(IW)) u_find_lo (
    .vec    (search_vec),
    .found  (lo_found),
    .onehot (lo_onehot),
    .index  (lo_index)
  );

  assign win_onehot = hi_found ? hi_onehot : lo_onehot;
  assign win_index  = hi_found ? hi_index  : lo_index;
  assign owner_req  = |(req & grant);

  always_comb begin
    // NOTE: every next-state variable gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    state_d   = state;
    grant_d   = grant;
    index_d   = grant_index;
    valid_d   = grant_valid;
    preempt_d = 1'b0;
    ptr_d     = ptr;
    hold_d    = hold_cnt;

    case (state)
      IDLE: begin
        if (lo_found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          index_d = win_index;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (owner_req) begin
          if (hold_cnt != HOLD_LAST) begin
            hold_d = hold_cnt + HW'(1);
          end else if (lo_found) begin
            grant_d   = win_onehot;
            index_d   = win_index;
            preempt_d = 1'b1;
            hold_d    = '0;
            ptr_d     = owner_next;
          end
        end else if (lo_found) begin
          grant_d = win_onehot;
          index_d = win_index;
          hold_d  = '0;
          ptr_d   = owner_next;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          index_d = '0;
          valid_d = 1'b0;
          hold_d  = '0;
          ptr_d   = owner_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values computed in the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      grant_index <= index_d;
      grant_valid <= valid_d;
      preempt     <= preempt_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
    end
  end

endmodule
